// File: rtl/xfiles_seq_pkg.sv
// Shared types and field layout for the X-FILES/DANA transaction sequencer.
package xfiles_seq_pkg;

  localparam int TID_W  = 16;
  localparam int ASID_W = 16;
  localparam int NNID_W = 32;
  localparam int DATA_W = 32;

  localparam int FUNCT_WRITE = 0;
  localparam int FUNCT_NEW   = 1;
  localparam int FUNCT_LAST  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_ASID,
    ST_NEW_REQ,
    ST_WAIT_TID,
    ST_WRITE,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_FINISH
  } seq_state_t;

  function automatic logic [6:0] mk_funct(input logic wr, input logic nw, input logic last);
    logic [6:0] f;
    f = 7'd0;
    f[FUNCT_WRITE] = wr;
    f[FUNCT_NEW]   = nw;
    f[FUNCT_LAST]  = last;
    return f;
  endfunction

endpackage

// File: rtl/xfiles_txn_sequencer_if.sv
// Arbiter core port: command channel, supervisor bit and response channel.
interface xfiles_txn_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_funct;
  logic [4:0]  cmd_rd;
  logic [63:0] cmd_rs1;
  logic [63:0] cmd_rs2;
  logic        s;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;

  modport master (
    output cmd_valid, cmd_funct, cmd_rd, cmd_rs1, cmd_rs2, s, resp_ready,
    input  cmd_ready, resp_valid, resp_data
  );

  modport slave (
    input  cmd_valid, cmd_funct, cmd_rd, cmd_rs1, cmd_rs2, s, resp_ready,
    output cmd_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/xfiles_seq_outreg.sv
// Single-entry valid/ready holding register for output words.
module xfiles_seq_outreg
  import xfiles_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  // Loads only happen while empty, so load never races a consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/xfiles_txn_sequencer.sv
// Drives one X-FILES/DANA arbiter port: ASID, new request, input stream, read-back.
// state      | meaning
// IDLE       | waiting for start; late responses drained
// SET_ASID   | supervisor command carrying the ASID
// NEW_REQ    | new write request for the latched NNID
// WAIT_TID   | waiting for the TID response
// WRITE      | input words passed straight through as write commands
// READ_REQ   | issuing one read request
// READ_WAIT  | waiting for the read response (only when output register empty)
// FINISH     | last word handed off, pulse done once it is consumed
module xfiles_txn_sequencer
  import xfiles_seq_pkg::*;
#(
  parameter int MAX_IO       = 64,
  parameter int RESP_TIMEOUT = 4096,
  parameter int RD_REG       = 0,
  localparam int CW          = $clog2(MAX_IO + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ASID_W-1:0]         asid,
  input  logic [NNID_W-1:0]         nnid,
  input  logic [CW-1:0]             num_in,
  input  logic [CW-1:0]             num_out,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  xfiles_txn_sequencer_if.master    arb,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [TID_W-1:0]          tid
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(RESP_TIMEOUT - 1);

  seq_state_t        state;
  logic [ASID_W-1:0] asid_q;
  logic [NNID_W-1:0] nnid_q;
  logic [CW-1:0]     n_in, n_out, wcnt, rcnt;
  logic [TW-1:0]     tmr;
  logic              live;
  logic              cmd_fire, resp_fire, w_last;
  logic              unused_resp_hi;

  assign cmd_fire       = arb.cmd_valid & arb.cmd_ready;
  assign resp_fire      = arb.resp_valid & arb.resp_ready;
  assign w_last         = (wcnt == n_in - CW'(1));
  assign busy           = (state != ST_IDLE);
  assign arb.cmd_rd     = 5'(RD_REG);
  assign unused_resp_hi = ^arb.resp_data[63:32];

  always_comb begin
    arb.cmd_valid  = 1'b0;
    arb.cmd_funct  = 7'd0;
    arb.cmd_rs1    = 64'd0;
    arb.cmd_rs2    = 64'd0;
    arb.s          = 1'b0;
    arb.resp_ready = 1'b0;
    in_ready       = 1'b0;
    case (state)
      ST_IDLE:      arb.resp_ready = live;
      ST_SET_ASID: begin
        arb.cmd_valid = 1'b1;
        arb.s         = 1'b1;
        arb.cmd_rs1   = {48'd0, asid_q};
      end
      ST_NEW_REQ: begin
        arb.cmd_valid = 1'b1;
        arb.cmd_funct = mk_funct(1'b1, 1'b1, 1'b0);
        arb.cmd_rs2   = {32'd0, nnid_q};
      end
      ST_WAIT_TID:  arb.resp_ready = 1'b1;
      ST_WRITE: begin
        arb.cmd_valid = in_valid;
        in_ready      = arb.cmd_ready;
        arb.cmd_funct = mk_funct(1'b1, 1'b0, w_last);
        arb.cmd_rs1   = {48'd0, tid};
        arb.cmd_rs2   = {32'd0, in_data};
      end
      ST_READ_REQ: begin
        arb.cmd_valid = 1'b1;
        arb.cmd_rs1   = {48'd0, tid};
      end
      ST_READ_WAIT: arb.resp_ready = ~out_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      asid_q <= '0;
      nnid_q <= '0;
      n_in   <= '0;
      n_out  <= '0;
      wcnt   <= '0;
      rcnt   <= '0;
      tmr    <= '0;
      tid    <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          asid_q <= asid;
          nnid_q <= nnid;
          n_in   <= (num_in == '0) ? CW'(1) : num_in;
          n_out  <= (num_out == '0) ? CW'(1) : num_out;
          wcnt   <= '0;
          rcnt   <= '0;
          err    <= 1'b0;
          state  <= ST_SET_ASID;
        end
        ST_SET_ASID: if (cmd_fire) state <= ST_NEW_REQ;
        ST_NEW_REQ: if (cmd_fire) begin
          tmr   <= TMR_LOAD;
          state <= ST_WAIT_TID;
        end
        ST_WAIT_TID: begin
          if (resp_fire) begin
            tid   <= arb.resp_data[TID_W-1:0];
            state <= ST_WRITE;
          end else if (tmr == '0) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        ST_WRITE: if (cmd_fire) begin
          wcnt <= wcnt + CW'(1);
          if (w_last) state <= ST_READ_REQ;
        end
        ST_READ_REQ: if (cmd_fire) begin
          tmr   <= TMR_LOAD;
          state <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          if (resp_fire) begin
            rcnt  <= rcnt + CW'(1);
            state <= (rcnt + CW'(1) == n_out) ? ST_FINISH : ST_READ_REQ;
          end else if (tmr == '0) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        ST_FINISH: if (!out_valid) begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  xfiles_seq_outreg u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      ((state == ST_READ_WAIT) && resp_fire),
    .load_data (arb.resp_data[DATA_W-1:0]),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_xfiles_txn_sequencer.sv
// Bench for xfiles_txn_sequencer: arbiter model plus command/output scoreboards.
module tb_xfiles_txn_sequencer;

  localparam int RESP_TIMEOUT = 4096;
  localparam int CW = 7;

  typedef struct packed {
    logic [6:0]  funct;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        s;
  } cmd_t;

  logic clk, rst, start;
  logic [15:0] asid;
  logic [31:0] nnid;
  logic [CW-1:0] num_in, num_out;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic busy, done, err;
  logic [15:0] tid;

  xfiles_txn_sequencer_if arb();

  xfiles_txn_sequencer #(.MAX_IO(64), .RESP_TIMEOUT(RESP_TIMEOUT), .RD_REG(0)) dut (
    .clk(clk), .rst(rst), .start(start), .asid(asid), .nnid(nnid),
    .num_in(num_in), .num_out(num_out),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .arb(arb), .busy(busy), .done(done), .err(err), .tid(tid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  cmd_t        cmdq[$];
  logic [31:0] outq[$];

  int r_dones, r_err_edges, r_gate_err, r_stab_err, r_stall_err;
  logic r_busy_at_err, r_err_after_start;

  function automatic logic [31:0] wword(input logic [15:0] a, input int i);
    return {a, 16'(i * 7 + 1)};
  endfunction

  function automatic logic [31:0] rword(input logic [15:0] a, input int i);
    return {~a, 16'(i * 13 + 3)};
  endfunction

  task automatic drive_idle();
    start = 1'b0; asid = '0; nnid = '0; num_in = '0; num_out = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    arb.cmd_ready = 1'b0; arb.resp_valid = 1'b0; arb.resp_data = '0;
  endtask

  // Runs one transaction cycle by cycle: bench arbiter, input source, output sink.
  task automatic run_txn(input logic [15:0] a, input logic [31:0] nn, input int nin, input int nout,
                         input logic [15:0] t, input bit bp, input int stall, input bit no_tid,
                         input int busy_start_cyc, input int abort_wr, input int budget);
    cmd_t e, cur, prev;
    int wi, ri, cyc, stall_left, wr_fires, edges, tail;
    bit tidp, rdp, first_out, prev_stall, finished, tmr_on;
    logic [31:0] ow;
    cmdq.delete(); outq.delete();
    cmdq.push_back({7'd0, {48'd0, a}, 64'd0, 1'b1});
    cmdq.push_back({7'd3, 64'd0, {32'd0, nn}, 1'b0});
    for (int i = 0; i < nin; i++)
      cmdq.push_back({(i == nin - 1) ? 7'd5 : 7'd1, {48'd0, t}, {32'd0, wword(a, i)}, 1'b0});
    for (int i = 0; i < nout; i++) begin
      cmdq.push_back({7'd0, {48'd0, t}, 64'd0, 1'b0});
      outq.push_back(rword(a, i));
    end
    wi = 0; ri = 0; cyc = 0; stall_left = stall; wr_fires = 0; edges = -1; tail = -1;
    tidp = 0; rdp = 0; first_out = 0; prev_stall = 0; finished = 0; tmr_on = 0; prev = '0;
    r_dones = 0; r_err_edges = -1; r_gate_err = 0; r_stab_err = 0; r_stall_err = 0;
    r_busy_at_err = 1'b1; r_err_after_start = 1'b1;
    while (!finished && cyc < budget) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == busy_start_cyc);
      if (cyc == 0) begin
        asid = a; nnid = nn; num_in = CW'(nin); num_out = CW'(nout);
      end else begin
        asid = ~a; nnid = ~nn; num_in = '0; num_out = '0;
      end
      in_valid = (wi < nin);
      in_data = wword(a, wi);
      arb.cmd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      arb.resp_valid = tidp | rdp;
      arb.resp_data = tidp ? {48'h5A5A_5A5A_5A5A, t} : {32'hFFFF_0000, rword(a, ri)};
      out_ready = (stall == 0) || (first_out && stall_left == 0);
      #1;
      if (tmr_on) edges++;
      if (cyc == 1) r_err_after_start = err;
      cur = {arb.cmd_funct, arb.cmd_rs1, arb.cmd_rs2, arb.s};
      if (!arb.cmd_ready && in_ready) r_gate_err++;
      if (prev_stall && (!arb.cmd_valid || cur !== prev)) r_stab_err++;
      prev_stall = arb.cmd_valid && !arb.cmd_ready;
      prev = cur;
      if (busy && out_valid && !out_ready && arb.resp_ready) r_stall_err++;
      if (arb.cmd_valid && arb.cmd_ready) begin
        n_total++;
        if (cmdq.size() == 0)
          $display("FAIL cmd_extra: got funct=%0h rs1=%0h rs2=%0h s=%0b, required no command",
                   cur.funct, cur.rs1, cur.rs2, cur.s);
        else begin
          e = cmdq.pop_front();
          if (cur !== e)
            $display("FAIL cmd_seq: got funct=%0h rs1=%0h rs2=%0h s=%0b, required funct=%0h rs1=%0h rs2=%0h s=%0b",
                     cur.funct, cur.rs1, cur.rs2, cur.s, e.funct, e.rs1, e.rs2, e.s);
          else n_pass++;
        end
        if (cur.funct == 7'd3) begin tidp = !no_tid; tmr_on = 1; edges = -1; end
        if (cur.funct == 7'd0 && !cur.s) rdp = 1;
        if (cur.funct[0] && !cur.funct[1]) wr_fires++;
      end
      if (arb.resp_valid && arb.resp_ready) begin
        if (tidp) tidp = 0;
        else if (rdp) begin rdp = 0; ri++; end
      end
      if (in_valid && in_ready) wi++;
      if (out_valid && out_ready) begin
        n_total++;
        if (outq.size() == 0)
          $display("FAIL out_extra: got %h, required no output", out_data);
        else begin
          ow = outq.pop_front();
          if (out_data !== ow) $display("FAIL out_data: got %h, required %h", out_data, ow);
          else n_pass++;
        end
      end
      if (first_out && stall_left > 0) stall_left--;
      if (out_valid) first_out = 1;
      if (done) r_dones++;
      if (err && tmr_on && r_err_edges < 0) begin
        r_err_edges = edges; r_busy_at_err = busy; finished = 1;
      end
      if (done && tail < 0) tail = 3;
      else if (tail > 0) tail--;
      if (tail == 0) finished = 1;
      if (abort_wr > 0 && wr_fires >= abort_wr) finished = 1;
      cyc++;
    end
    if (!finished) begin
      n_total++;
      $display("FAIL txn_budget: no completion after %0d cycles, required completion", budget);
    end
    if (r_dones > 0) begin
      n_total++;
      if (cmdq.size() != 0) $display("FAIL cmd_left: got %0d pending, required 0", cmdq.size());
      else n_pass++;
      n_total++;
      if (outq.size() != 0) $display("FAIL out_left: got %0d pending, required 0", outq.size());
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    logic [190:0] outs;
    rst = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    outs = {arb.cmd_valid, arb.s, arb.resp_ready, in_ready, out_valid, busy, done, err, tid,
            arb.cmd_funct, arb.cmd_rs1, arb.cmd_rs2, out_data};
    n_total++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h, required 0", outs); else n_pass++;
    n_total++;
    if (arb.cmd_rd !== 5'd0) $display("FAIL cmd_rd: got %0d, required 0", arb.cmd_rd); else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (arb.resp_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_drain: got resp_ready=%b busy=%b, required 1 0", arb.resp_ready, busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_txn(16'h1234, 32'h0, 30, 30, 16'h0005, 0, 0, 0, -1, 0, 2000);
    n_total++;
    if (r_dones != 1) $display("FAIL basic_done: got %0d pulses, required 1", r_dones); else n_pass++;
    n_total++;
    if (tid !== 16'h0005 || err !== 1'b0)
      $display("FAIL basic_tid: got tid=%h err=%b, required 0005 0", tid, err);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    run_txn(16'h0BEE, 32'h00C0_FFEE, 17, 9, 16'h00A5, 1, 0, 0, -1, 0, 3000);
    n_total++;
    if (r_stab_err != 0) $display("FAIL bp_stable: got %0d unstable stalls, required 0", r_stab_err); else n_pass++;
    n_total++;
    if (r_gate_err != 0) $display("FAIL bp_in_ready: got %0d gated cycles, required 0", r_gate_err); else n_pass++;
    n_total++;
    if (r_dones != 1) $display("FAIL bp_done: got %0d pulses, required 1", r_dones); else n_pass++;
  endtask

  task automatic test_output_stall();
    run_txn(16'h7777, 32'h1, 6, 12, 16'h0042, 0, 100, 0, -1, 0, 3000);
    n_total++;
    if (r_stall_err != 0) $display("FAIL stall_resp_ready: got %0d open cycles, required 0", r_stall_err); else n_pass++;
    n_total++;
    if (r_dones != 1) $display("FAIL stall_done: got %0d pulses, required 1", r_dones); else n_pass++;
  endtask

  task automatic test_timeout();
    run_txn(16'h00AA, 32'hDEAD, 4, 4, 16'h0001, 0, 0, 1, -1, 0, RESP_TIMEOUT + 200);
    n_total++;
    if (r_err_edges != RESP_TIMEOUT)
      $display("FAIL timeout_cycles: got %0d, required %0d", r_err_edges, RESP_TIMEOUT);
    else n_pass++;
    n_total++;
    if (r_busy_at_err !== 1'b0) $display("FAIL timeout_busy: got %b, required 0", r_busy_at_err); else n_pass++;
    n_total++;
    if (r_dones != 0) $display("FAIL timeout_done: got %0d pulses, required 0", r_dones); else n_pass++;
    run_txn(16'h00AB, 32'hBEEF, 3, 2, 16'h0009, 0, 0, 0, -1, 0, 1000);
    n_total++;
    if (r_err_after_start !== 1'b0) $display("FAIL err_clear: got %b, required 0", r_err_after_start); else n_pass++;
    n_total++;
    if (r_dones != 1) $display("FAIL recover_done: got %0d pulses, required 1", r_dones); else n_pass++;
  endtask

  task automatic test_boundary();
    run_txn(16'h0101, 32'h0000_0010, 1, 1, 16'h0003, 0, 0, 0, 4, 0, 500);
    n_total++;
    if (r_dones != 1) $display("FAIL boundary_done: got %0d pulses, required 1", r_dones); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    logic [190:0] outs;
    run_txn(16'h5555, 32'h22, 20, 5, 16'h0011, 0, 0, 0, -1, 10, 500);
    @(posedge clk);
    #2;
    n_total++;
    if (busy !== 1'b1) $display("FAIL pre_reset_busy: got %b, required 1", busy); else n_pass++;
    rst = 1'b0;
    #1;
    outs = {arb.cmd_valid, arb.s, arb.resp_ready, in_ready, out_valid, busy, done, err, tid,
            arb.cmd_funct, arb.cmd_rs1, arb.cmd_rs2, out_data};
    n_total++;
    if (outs !== '0) $display("FAIL async_reset: got %h, required 0", outs); else n_pass++;
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(16'h6666, 32'h33, 20, 5, 16'h0012, 0, 0, 0, -1, 0, 1000);
    n_total++;
    if (r_dones != 1) $display("FAIL post_reset_done: got %0d pulses, required 1", r_dones); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_output_stall();
    test_timeout();
    test_boundary();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
